// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared definitions for the seven-segment display scanner.
//               Active-low segment patterns ({g,f,e,d,c,b,a}), all-off
//               constants and the scan FSM state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Width of the blanking down-counter; covers the full legal range 0..4999.
    localparam int c_CNT_W = 13;

    // Hex-to-segment patterns, entry n holds the glyph for nibble value n.
    localparam logic [15:0][6:0] c_SEG_LUT = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to active-low seven-segment decoder.
// Ports       : i_nibble [3:0] - hex digit to decode
//               o_seg    [6:0] - segment pattern {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = c_SEG_LUT[i_nibble];

endmodule
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// Module      : display_scan
// Description : Four-digit common-anode seven-segment scanner. Each rising
//               edge of clk_dividido (sampled as data) advances the digit,
//               with an all-off blanking gap of BLANK_CYCLES clk cycles at
//               every digit change. The 16-bit value is latched once per
//               frame, when digit 0 becomes active.
//               Optional macro DISPLAY_SCAN_LZB_EN enables leading-zero
//               blanking of digits 3..1 (anodes still scan).
// Ports       : clk          - system clock, rising edge
//               rst_n        - synchronous reset, active-low
//               clk_dividido - scan rate square wave (data, not a clock)
//               value [15:0] - four hex digits, [3:0] is rightmost
//               dp_in [3:0]  - per-digit decimal point, active-high
//               an    [3:0]  - anode enables, active-low, [3] leftmost
//               seg   [6:0]  - segments {g,f,e,d,c,b,a}, active-low
//               dp           - decimal point, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan
    import display_pkg::*;
#(
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_dividido,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [c_CNT_W-1:0] c_BLANK      = c_CNT_W'(BLANK_CYCLES);
    localparam bit                 c_BLANK_ZERO = (BLANK_CYCLES == 0);

    logic               r_cd_q;
    logic               r_tick;
    logic               w_tick;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_inc;
    logic [15:0]        r_frame;
    logic [3:0]         r_frame_dp;
    logic [3:0]         w_nibble;
    logic [6:0]         w_seg_dec;
    logic               w_lz;
    logic [3:0]         w_an_nxt;
    logic [6:0]         w_seg_nxt;
    logic               w_dp_nxt;

    // Rising-edge detect; the tick is registered so the FSM sees it one
    // cycle after the input rises.
    assign w_tick    = clk_dividido & ~r_cd_q;
    assign w_idx_inc = r_idx + 2'd1;

    // ------------------------------------------------------------------
    // State register and scan datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cd_q     <= 1'b1;   // input high at reset must not tick
            r_tick     <= 1'b0;
            r_state    <= OFF;
            r_cnt      <= '0;
            r_idx      <= 2'd3;   // first tick lands on digit 0
            r_frame    <= '0;
            r_frame_dp <= '0;
        end else begin
            r_cd_q  <= clk_dividido;
            r_tick  <= w_tick;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_tick) begin
                r_idx <= w_idx_inc;
                // Latch a whole frame only as digit 0 starts.
                if (w_idx_inc == 2'd0) begin
                    r_frame    <= value;
                    r_frame_dp <= dp_in;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            OFF, SHOW, BLANK: begin
                if (r_tick) begin
                    if (c_BLANK_ZERO) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = c_BLANK;
                    end
                end else if (r_state == BLANK) begin
                    // Leave as the counter hits zero: exactly BLANK_CYCLES
                    // cycles are spent in BLANK.
                    if (r_cnt <= c_CNT_W'(1)) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered below)
    // ------------------------------------------------------------------
    assign w_nibble = r_frame[{r_idx, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

`ifdef DISPLAY_SCAN_LZB_EN
    // Digit k blanks when it and every digit to its left are zero.
    always_comb begin
        w_lz = 1'b0;
        case (r_idx)
            2'd3:    w_lz = (r_frame[15:12] == 4'h0);
            2'd2:    w_lz = (r_frame[15:8]  == 8'h00);
            2'd1:    w_lz = (r_frame[15:4]  == 12'h000);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (r_state == SHOW) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_lz ? SEG_OFF : w_seg_dec;
            w_dp_nxt  = ~r_frame_dp[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
            dp  <= w_dp_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan
// Description : Self-checking bench for display_scan. A timeline model
//               (time since last accepted tick, digit number, latched frame)
//               predicts {an,seg,dp} every cycle; directed steps pin the
//               model with literal expectations, then random scan periods,
//               value changes and reset pulses follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan;

    localparam int B = 100;
    localparam logic [11:0] c_OFF_W = 12'hFFF;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam logic [6:0] c_LEAD = 7'b1111111;
`else
    localparam logic [6:0] c_LEAD = 7'b1000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_dividido;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_chk = 0;
    int n_err = 0;

    display_scan #(.BLANK_CYCLES(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_dividido (clk_dividido),
        .value        (value),
        .dp_in        (dp_in),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     nm, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [11:0] show_word(input int idx, input logic [15:0] fr,
                                              input logic [3:0] fdp);
        logic [3:0]  a;
        logic [6:0]  s;
        logic [15:0] sh;
        sh     = fr >> (4 * idx);
        a      = 4'hF;
        a[idx] = 1'b0;
        s      = hex7(sh[3:0]);
`ifdef DISPLAY_SCAN_LZB_EN
        if (idx != 0 && sh == 16'h0000) s = 7'b1111111;
`endif
        return {a, s, ~fdp[idx]};
    endfunction

    // ------------------------------------------------------------------
    // Reference model + per-cycle compare. Inputs change on negedges, so
    // at posedge+1 they still hold the values the DUT just sampled.
    // ------------------------------------------------------------------
    int          cyc       = 0;
    int          m_idx     = 3;
    logic        m_pend    = 1'b0;
    logic        m_cdq     = 1'b1;
    logic        m_started = 1'b0;
    int          m_t       = 0;
    logic [15:0] m_frame   = 16'h0;
    logic [3:0]  m_fdp     = 4'h0;
    logic [11:0] m_exp     = 12'hFFF;
    logic [11:0] exp_w;

    always @(posedge clk) begin
        #1;
        cyc++;
        exp_w = (!rst_n) ? c_OFF_W : m_exp;
        check("cycle", {an, seg, dp}, exp_w);
        if (!rst_n) begin
            m_idx     = 3;
            m_pend    = 1'b0;
            m_cdq     = 1'b1;
            m_started = 1'b0;
        end else begin
            // A rise seen at one edge takes effect on the digit at the next.
            if (m_pend) begin
                m_idx = (m_idx + 1) % 4;
                if (m_idx == 0) begin
                    m_frame = value;
                    m_fdp   = dp_in;
                end
                m_started = 1'b1;
                m_t       = cyc;
            end
            m_pend = clk_dividido && !m_cdq;
            m_cdq  = clk_dividido;
        end
        if (!m_started || (cyc - m_t) < B) m_exp = c_OFF_W;
        else                                m_exp = show_word(m_idx, m_frame, m_fdp);
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic tick_show(input logic [3:0] ea, input logic [6:0] es, input logic ed,
                             input string nm);
        @(negedge clk) clk_dividido = 1'b1;
        repeat (B + 2) @(posedge clk);
        #2 check({nm, "_blank"}, {an, seg, dp}, c_OFF_W);
        @(posedge clk);
        #2 check(nm, {an, seg, dp}, {ea, es, ed});
        @(negedge clk) clk_dividido = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) value = 16'($urandom);
            if ($urandom_range(0, 24) == 0) dp_in = 4'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        clk_dividido = 1'b1;
        value        = 16'h12AF;
        dp_in        = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Input high through reset release must not start a scan.
        repeat (120) @(negedge clk);
        check("reset_idle", {an, seg, dp}, c_OFF_W);
        clk_dividido = 1'b0;
        repeat (20) @(negedge clk);

        tick_show(4'b1110, 7'b0001110, 1'b1, "first_F");
        tick_show(4'b1101, 7'b0001000, 1'b1, "wrap_A");
        tick_show(4'b1011, 7'b0100100, 1'b1, "wrap_2");
        tick_show(4'b0111, 7'b1111001, 1'b1, "wrap_1");
        tick_show(4'b1110, 7'b0001110, 1'b1, "wrap_F");

        tick_show(4'b1101, 7'b0001000, 1'b1, "latch_A");
        value = 16'h0000;
        tick_show(4'b1011, 7'b0100100, 1'b1, "latch_old2");
        tick_show(4'b0111, 7'b1111001, 1'b1, "latch_old1");
        tick_show(4'b1110, 7'b1000000, 1'b1, "latch_new0");

        value = 16'h0005;
        tick_show(4'b1101, c_LEAD, 1'b1, "lzb_z1");
        tick_show(4'b1011, c_LEAD, 1'b1, "lzb_z2");
        tick_show(4'b0111, c_LEAD, 1'b1, "lzb_z3");
        tick_show(4'b1110, 7'b0010010, 1'b1, "lzb_d0");
        tick_show(4'b1101, c_LEAD, 1'b1, "lzb_d1");
        tick_show(4'b1011, c_LEAD, 1'b1, "lzb_d2");
        tick_show(4'b0111, c_LEAD, 1'b1, "lzb_d3");

        // One-cycle reset while digit 3 is showing.
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #2 check("midreset_off", {an, seg, dp}, c_OFF_W);
        @(negedge clk) rst_n = 1'b1;
        value = 16'h12AF;
        dp_in = 4'b0001;
        repeat (10) @(negedge clk);
        tick_show(4'b1110, 7'b0001110, 1'b0, "after_reset");

        for (int i = 0; i < 60; i++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 60));
            lo = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 60))
                                             : int'($urandom_range(60, 260));
            @(negedge clk) clk_dividido = 1'b1;
            rand_cycles(hi);
            clk_dividido = 1'b0;
            rand_cycles(lo);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scan.md
# display_scan

Four-digit seven-segment display scanner; consumer of the divided clock `clk_dividido` (10 kHz square wave generated in the `clk` domain). Detects each rising edge of `clk_dividido` as a scan tick, cycles the common-anode digits, and drives the hex segments for a 16-bit value; here that value is the Gray decoder's binary result. Inserts a short all-off blanking interval at every digit change to suppress ghosting. Latches the displayed value once per frame so a digit set never mixes old and new values.

## Interface
- `BLANK_CYCLES`, default 100: `clk` cycles of all-anodes-off after each digit switch. Legal range 0..4999; must stay below the tick period.
- `clk`  in  1  100 MHz system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clk_dividido`  in  1  10 kHz scan clock, already registered in the `clk` domain; used as data only, never as a clock.
- `value`  in  16  four hex digits; `value[3:0]` is digit 0, the rightmost.
- `dp_in`  in  4  per-digit decimal point, active-high.
- `an`  out  4  anode enables, active-low; `an[3]` is the leftmost digit.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- Edge detect: `cd_q` ← `clk_dividido` every cycle. `tick = clk_dividido & ~cd_q`. Reset sets `cd_q`=1, so an input that is high at reset does not produce a tick.
- Digit index `idx` is 2 bits and resets to 3. Each tick sets `idx` ← `idx`+1, wrapping 3→0.
- Frame latch: on a tick whose new `idx` is 0, `frame` ← `value` and `frame_dp` ← `dp_in`. `value` is sampled at no other time.
- FSM states:
  - OFF (reset state): all outputs off; on a tick, go to BLANK.
  - BLANK: `an`=1111, `seg`=1111111, `dp`=1. Down-counter loaded with `BLANK_CYCLES` on entry; go to SHOW when it reaches 0. If `BLANK_CYCLES`=0, go straight from a tick to SHOW.
  - SHOW: `an` has only bit `idx` low, `seg` = hex decode of `frame[4*idx+3:4*idx]`, `dp` = ~`frame_dp[idx]`. On a tick, go to BLANK.
- A tick while in BLANK advances `idx` and reloads the counter. This only happens with an illegal parameter value, but the behaviour is still defined.
- Hex decode examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
- Reset asserted in any state: on the next edge, return to OFF with `idx`=3 and the counter at 0. Outputs are off on the following cycle.

## Timing
- All outputs are registered. Reset value: `an`=1111, `seg`=1111111, `dp`=1.
- The tick is asserted one cycle after `clk_dividido` rises. The FSM changes state on the next edge, and the outputs follow one cycle after that.
- Latency from the `clk_dividido` rising edge to the first SHOW output: `BLANK_CYCLES`+3 cycles.
- Each digit is displayed for 10 000 − `BLANK_CYCLES` cycles per tick period. The full frame rate is 2.5 kHz.

## Configuration
- `DISPLAY_SCAN_LZB_EN` defined: leading-zero blanking. In SHOW, digit k (k=3..1) shows `seg`=1111111 when `frame` nibbles k..3 are all zero, but its anode still pulses. Digit 0 is always shown, and `dp` is unaffected.
- Macro undefined: all four digits are always decoded.

## Structure
- Package `display_pkg`: the 16-entry segment pattern constant array, `SEG_OFF`=7'b1111111, `AN_OFF`=4'b1111, and the FSM state enum (OFF, BLANK, SHOW).
- Sub-module `hex_to_7seg`: combinational, 4-bit nibble in, 7-bit active-low pattern out.
- The tick detect, counter and FSM stay in `display_scan`.

## Test plan
- Reset: assert `rst_n`=0 with `clk_dividido`=1 for 3 cycles, then release and hold the input high for 100 cycles → `an`=1111, `seg`=1111111, `dp`=1, and no tick fires.
- First tick: `value`=16'h12AF, `BLANK_CYCLES`=100, then raise `clk_dividido` → `an`=1111 for 100 cycles, then `an`=1110 and `seg`=0001110 (F), arriving exactly `BLANK_CYCLES`+3 cycles after the input rose.
- Wrap: drive 5 ticks → `an` sequence 1110, 1101, 1011, 0111, 1110, with `seg` showing F, A, 2, 1, F.
- Frame latch: change `value` to 16'h0000 while digit 1 is in SHOW → digits 2 and 3 still show 2 and 1; the new value appears only from the next digit-0 tick.
- LZB: with `DISPLAY_SCAN_LZB_EN` defined, `value`=16'h0005 → digits 3..1 show `seg`=1111111 with their anodes pulsing, and digit 0 shows 0010010. With the macro undefined, digits 3..1 show 1000000.
- Mid-operation reset: `rst_n`=0 for 1 cycle during SHOW → outputs are off on the following cycle. The next tick after release lights digit 0 (`an`=1110).
